// File: rtl/uart_tx_fifo.sv
// First-word-fall-through FIFO buffering bytes for a UART transmitter.
// A sticky overflow flag records any write attempted while the FIFO is full.
module uart_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     axiiv,
  input  logic [WIDTH-1:0]         axiid,
  output logic                     axiready,
  output logic                     axiov,
  output logic [WIDTH-1:0]         axiod,
  input  logic                     uart_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  input  logic                     clear_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             r_overflow;

  logic             w_full;
  logic             w_empty;
  logic             w_wr;
  logic             w_rd;

  // Handshake: a beat transfers on a rising edge only when valid and ready are
  // both high; valid never waits on ready, and data is held while valid && !ready.
  assign w_full   = (r_count == FULL_CNT);
  assign w_empty  = (r_count == '0);
  assign w_wr     = axiiv && !w_full;
  assign w_rd     = !w_empty && uart_ready;

  assign axiready = !w_full;
  assign axiov    = !w_empty;
  assign axiod    = r_mem[r_rd_ptr];
  assign count    = r_count;
  assign overflow = r_overflow;

  // Storage is not reset; pointers and count alone define which entries are live.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= axiid;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_rd) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      // Set has priority over clear when both happen on the same edge.
      if (axiiv && w_full) begin
        r_overflow <= 1'b1;
      end else if (clear_overflow) begin
        r_overflow <= 1'b0;
      end
    end
  end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO entries (power of two, >= 2).
REQ-002 SHALL have parameter WIDTH, default 8, data bits per entry.
REQ-003 SHALL have port clk, input, 1, sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset; one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port axiiv, input, 1, producer data valid.
REQ-006 SHALL have port axiid, input, WIDTH, producer data.
REQ-007 SHALL have port axiready, output, 1, FIFO can accept a write.
REQ-008 SHALL have port axiov, output, 1, head entry valid toward UART transmitter.
REQ-009 SHALL have port axiod, output, WIDTH, head entry data.
REQ-010 SHALL have port uart_ready, input, 1, UART transmitter accepts byte (driven by its axiready).
REQ-011 SHALL have port count, output, $clog2(DEPTH)+1, current occupancy.
REQ-012 SHALL have port overflow, output, 1, sticky flag: write attempted while full.
REQ-013 SHALL have port clear_overflow, input, 1, synchronous clear of overflow.

Function
REQ-014 SHALL accept a write on a rising edge iff axiiv && axiready; data stored at write pointer, pointer +1.
REQ-015 SHALL perform a read on a rising edge iff axiov && uart_ready; read pointer +1.
REQ-016 SHALL drive axiready = (count != DEPTH), combinationally from registered state.
REQ-017 SHALL drive axiov = (count != 0), first-word-fall-through; axiod = entry at read pointer whenever axiov is high.
REQ-018 SHALL hold axiod stable while axiov high and uart_ready low.
REQ-019 SHALL make a byte written into an empty FIFO at edge N visible on axiov/axiod in the cycle after edge N (1-cycle latency).
REQ-020 SHALL, on simultaneous accepted write and read, leave count unchanged and advance both pointers.
REQ-021 SHALL, when full, keep axiready low even if a read occurs in the same cycle; the write is not accepted.
REQ-022 SHALL, when empty, ignore uart_ready; no pointer or count change.
REQ-023 SHALL wrap pointers modulo DEPTH using $clog2(DEPTH)-bit counters; count ranges 0..DEPTH inclusive.
REQ-024 SHALL set overflow on any edge where axiiv is high and count == DEPTH; data discarded, FIFO contents unchanged.
REQ-025 SHALL clear overflow on an edge where clear_overflow is high, unless the set condition holds on that same edge (set wins).
REQ-026 SHALL preserve byte order: bytes leave on axiod in acceptance order, none duplicated or dropped except per REQ-024.

Reset
REQ-027 SHALL, while rst_n low, force read pointer, write pointer and count to 0, overflow to 0, axiov to 0, axiready to 1, independent of clk.
REQ-028 SHALL discard all stored entries on reset, including mid-transfer; storage array contents need not be cleared.
REQ-029 SHALL resume accepting writes on the first rising edge after rst_n deasserts.

Verification
REQ-030 SHALL cover: reset, write 0x41 with uart_ready=0 -> next cycle axiov=1, axiod=0x41, count=1; held until uart_ready=1, then count=0, axiov=0.
REQ-031 SHALL cover: write 0x01..0x10 back-to-back, uart_ready=0 -> count=16, axiready=0; then uart_ready=1 -> outputs 0x01..0x10 in order, one per cycle.
REQ-032 SHALL cover: full FIFO, axiiv=1 with 0xFF -> overflow=1, count stays 16, 0xFF never appears; clear_overflow pulse -> overflow=0.
REQ-033 SHALL cover: count=5 with simultaneous write and read for 20 cycles -> count stays 5, order preserved across pointer wrap.
REQ-034 SHALL cover: rst_n low for 3 ns between clock edges with count=7 -> count=0, axiov=0, axiready=1 immediately; next write 0x55 appears as first output.
REQ-035 SHALL cover: full FIFO, axiiv=1 and uart_ready=1 same cycle -> read occurs, write rejected, overflow=1, count=15.
